res_port_arbiter: RTL and testbench

//  Shares the single-port 16384x8 result RAM (res_*) between two requesters: M0 = distance-transform

---
 rtl/dt_pkg.sv | 18 +
 rtl/res_port_arbiter_rd_tag_pipe.sv | 34 +++
 rtl/res_port_arbiter.sv | 107 ++++++++++
 tb/tb_res_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dt_pkg.sv
// Shared types and widths for the distance-transform result path.
// Holds the result RAM geometry and the master identifiers used by the arbiter.
package dt_pkg;

  localparam int RES_AW = 14;
  localparam int RES_DW = 8;

  typedef enum logic {
    MST_DT   = 1'b0,
    MST_HOST = 1'b1
  } mst_id_t;

  typedef struct packed {
    logic    valid;
    mst_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/res_port_arbiter_rd_tag_pipe.sv
// Delay line of read tags that tracks outstanding reads through the RAM latency.
// Each returning read raises the rvalid of the master that issued it.
module rd_tag_pipe
  import dt_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  mst_id_t push_id,
  output logic    m0_rvalid,
  output logic    m1_rvalid
);

  rd_tag_t              tag_in;
  rd_tag_t [RD_LAT:0]   pipe;

  assign tag_in.valid = push;
  assign tag_in.id    = push_id;

  // Stage 0 holds a tag in the cycle the RAM sees the strobe; the last stage aligns with res_di.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe <= '0;
    end else begin
      pipe <= {pipe[RD_LAT-1:0], tag_in};
    end
  end

  assign m0_rvalid = pipe[RD_LAT].valid && (pipe[RD_LAT].id == MST_DT);
  assign m1_rvalid = pipe[RD_LAT].valid && (pipe[RD_LAT].id == MST_HOST);

endmodule

// File: rtl/res_port_arbiter.sv
// Two-master arbiter for the single-port result RAM: DT engine first, host
// guaranteed a slot after MAX_WAIT consecutive refusals.
module res_port_arbiter
  import dt_pkg::*;
#(
  parameter int AW       = RES_AW,
  parameter int DW       = RES_DW,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          res_rd,
  output logic          res_wr,
  output logic [AW-1:0] res_addr,
  output logic [DW-1:0] res_do,
  input  logic [DW-1:0] res_di
);

  logic [7:0]    wait_cnt;
  logic          starve;
  logic          accept;
  logic          acc_we;
  mst_id_t       acc_id;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;

  assign starve = (wait_cnt == 8'(MAX_WAIT));

  // Grants are held low during reset so no requester believes it was accepted.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (reset) begin
      if (starve && m1_req) begin
        m1_gnt = 1'b1;
      end else if (m0_req) begin
        m0_gnt = 1'b1;
      end else if (m1_req) begin
        m1_gnt = 1'b1;
      end
    end
  end

  assign accept    = m0_gnt || m1_gnt;
  assign acc_id    = m1_gnt ? MST_HOST : MST_DT;
  assign acc_we    = m1_gnt ? m1_we    : m0_we;
  assign acc_addr  = m1_gnt ? m1_addr  : m0_addr;
  assign acc_wdata = m1_gnt ? m1_wdata : m0_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_rd   <= 1'b0;
      res_wr   <= 1'b0;
      res_addr <= '0;
      res_do   <= '0;
    end else if (accept) begin
      res_rd   <= !acc_we;
      res_wr   <= acc_we;
      res_addr <= acc_addr;
      res_do   <= acc_wdata;
    end else begin
      res_rd   <= 1'b0;
      res_wr   <= 1'b0;
    end
  end

  // Counts consecutive refused host cycles; any host grant or dropped request restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (!m1_req || m1_gnt) begin
      wait_cnt <= '0;
    end else if (!starve) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk       (clk),
    .reset     (reset),
    .push      (accept && !acc_we),
    .push_id   (acc_id),
    .m0_rvalid (m0_rvalid),
    .m1_rvalid (m1_rvalid)
  );

  assign m0_rdata = res_di;
  assign m1_rdata = res_di;

endmodule

// File: tb/tb_res_port_arbiter.sv
// Bench for res_port_arbiter: RAM model, queue-based reference model checked every
// cycle, directed scenarios with literal expectations, plus a RD_LAT=3 instance.
module tb_res_port_arbiter;
  import dt_pkg::*;

  localparam int MAX_WAIT = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [13:0] m0_addr;
  logic [7:0]  m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [13:0] m1_addr;
  logic [7:0]  m1_wdata, m1_rdata;
  logic        res_rd, res_wr;
  logic [13:0] res_addr;
  logic [7:0]  res_do, res_di;

  logic        d3_m0_req, d3_m0_we, d3_m0_gnt, d3_m0_rvalid;
  logic [13:0] d3_m0_addr;
  logic [7:0]  d3_m0_wdata, d3_m0_rdata;
  logic        d3_m1_req, d3_m1_we, d3_m1_gnt, d3_m1_rvalid;
  logic [13:0] d3_m1_addr;
  logic [7:0]  d3_m1_wdata, d3_m1_rdata;
  logic        d3_res_rd, d3_res_wr;
  logic [13:0] d3_res_addr;
  logic [7:0]  d3_res_do, d3_res_di;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  res_port_arbiter #(.RD_LAT(1), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .res_rd(res_rd), .res_wr(res_wr), .res_addr(res_addr), .res_do(res_do), .res_di(res_di)
  );

  res_port_arbiter #(.RD_LAT(3), .MAX_WAIT(MAX_WAIT)) dut3 (
    .clk(clk), .reset(reset),
    .m0_req(d3_m0_req), .m0_we(d3_m0_we), .m0_addr(d3_m0_addr), .m0_wdata(d3_m0_wdata),
    .m0_gnt(d3_m0_gnt), .m0_rvalid(d3_m0_rvalid), .m0_rdata(d3_m0_rdata),
    .m1_req(d3_m1_req), .m1_we(d3_m1_we), .m1_addr(d3_m1_addr), .m1_wdata(d3_m1_wdata),
    .m1_gnt(d3_m1_gnt), .m1_rvalid(d3_m1_rvalid), .m1_rdata(d3_m1_rdata),
    .res_rd(d3_res_rd), .res_wr(d3_res_wr), .res_addr(d3_res_addr), .res_do(d3_res_do),
    .res_di(d3_res_di)
  );

  // Result RAM with one cycle of read latency.
  logic [7:0] ram [16384];
  always @(posedge clk) begin
    if (res_wr) ram[res_addr] <= res_do;
    if (res_rd) res_di <= ram[res_addr];
  end

  // Three-cycle RAM for the RD_LAT=3 instance; contents are a fixed function of the address.
  logic [7:0] d3_p1, d3_p2;
  always @(posedge clk) begin
    d3_p1     <= d3_res_addr[7:0] ^ 8'hA5;
    d3_p2     <= d3_p1;
    d3_res_di <= d3_p2;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic w0, input logic [13:0] a0,
                               input logic [7:0] d0, input logic r1, input logic w1,
                               input logic [13:0] a1, input logic [7:0] d1);
    @(posedge clk);
    #1;
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
  endtask

  // Reference model: reads are outstanding records with a due cycle; memory tracks accepted writes.
  typedef struct {
    int         due;
    bit         id;
    bit         known;
    logic [7:0] data;
  } pend_t;

  pend_t      pend[$];
  logic [7:0] mdl_mem [int];

  initial begin : compare
    bit          e_rd, e_wr;
    logic [13:0] e_addr;
    logic [7:0]  e_do;
    int          refused;
    bit          v0, v1, k0, k1, g0, g1, we;
    logic [7:0]  dd0, dd1;
    logic [13:0] a;
    logic [7:0]  wd;
    e_rd = 0; e_wr = 0; e_addr = '0; e_do = '0; refused = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        e_rd = 0; e_wr = 0; e_addr = '0; e_do = '0; refused = 0;
        pend.delete();
        checkOutput("rst_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd0);
        checkOutput("rst_ram", {8'd0, res_rd, res_wr, res_addr, res_do}, 32'd0);
        checkOutput("rst_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
      end else begin
        checkOutput("res_rd", {31'd0, res_rd}, {31'd0, e_rd});
        checkOutput("res_wr", {31'd0, res_wr}, {31'd0, e_wr});
        checkOutput("res_addr", {18'd0, res_addr}, {18'd0, e_addr});
        checkOutput("res_do", {24'd0, res_do}, {24'd0, e_do});
        v0 = 0; v1 = 0; k0 = 0; k1 = 0; dd0 = '0; dd1 = '0;
        for (int i = pend.size() - 1; i >= 0; i--) begin
          if (pend[i].due == cyc) begin
            if (pend[i].id) begin v1 = 1; k1 = pend[i].known; dd1 = pend[i].data; end
            else            begin v0 = 1; k0 = pend[i].known; dd0 = pend[i].data; end
            pend.delete(i);
          end
        end
        checkOutput("m0_rvalid", {31'd0, m0_rvalid}, {31'd0, v0});
        checkOutput("m1_rvalid", {31'd0, m1_rvalid}, {31'd0, v1});
        if (v0 && k0) checkOutput("m0_rdata", {24'd0, m0_rdata}, {24'd0, dd0});
        if (v1 && k1) checkOutput("m1_rdata", {24'd0, m1_rdata}, {24'd0, dd1});
        g1 = m1_req && (refused == MAX_WAIT || !m0_req);
        g0 = m0_req && !g1;
        checkOutput("m0_gnt", {31'd0, m0_gnt}, {31'd0, g0});
        checkOutput("m1_gnt", {31'd0, m1_gnt}, {31'd0, g1});
        checkOutput("wait_cnt", {24'd0, dut.wait_cnt}, refused);
        if (g0 || g1) begin
          we = g1 ? m1_we : m0_we;
          a  = g1 ? m1_addr : m0_addr;
          wd = g1 ? m1_wdata : m0_wdata;
          e_rd = !we; e_wr = we; e_addr = a; e_do = wd;
          if (we) mdl_mem[int'(a)] = wd;
          else pend.push_back('{due: cyc + 2, id: g1,
                                 known: mdl_mem.exists(int'(a)),
                                 data: mdl_mem.exists(int'(a)) ? mdl_mem[int'(a)] : 8'h00});
        end else begin
          e_rd = 0; e_wr = 0;
        end
        if (m1_req && !g1) refused = (refused < MAX_WAIT) ? refused + 1 : refused;
        else refused = 0;
      end
    end
  end

  initial begin : stimulus
    logic [13:0] rd_addr [3];
    int          pulses;
    rd_addr[0] = 14'h0081; rd_addr[1] = 14'h0082; rd_addr[2] = 14'h0101;
    reset = 1'b0;
    m0_req = 1; m0_we = 0; m0_addr = 14'h0055; m0_wdata = 0;
    m1_req = 1; m1_we = 0; m1_addr = 14'h0066; m1_wdata = 0;
    d3_m0_req = 0; d3_m0_we = 0; d3_m0_addr = 0; d3_m0_wdata = 0;
    d3_m1_req = 0; d3_m1_we = 0; d3_m1_addr = 0; d3_m1_wdata = 0;
    @(negedge clk);
    checkOutput("lit_gnt_in_reset", {30'd0, m0_gnt, m1_gnt}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] M0-only reads after host preload");
    applyStimulus(0, 0, 0, 0, 1, 1, 14'h0081, 8'd3);
    applyStimulus(0, 0, 0, 0, 1, 1, 14'h0082, 8'd4);
    applyStimulus(0, 0, 0, 0, 1, 1, 14'h0101, 8'd5);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      if (k < 3) applyStimulus(1, 0, rd_addr[k], 0, 0, 0, 0, 0);
      else       applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("lit_m0only_gnt", {31'd0, m0_gnt}, (k < 3) ? 32'd1 : 32'd0);
      checkOutput("lit_m0only_rvalid", {31'd0, m0_rvalid}, (k >= 2) ? 32'd1 : 32'd0);
      checkOutput("lit_m0only_m1rvalid", {31'd0, m1_rvalid}, 32'd0);
      if (k >= 2) checkOutput("lit_m0only_rdata", {24'd0, m0_rdata}, 32'(k + 1));
    end

    $display("[TB] reset during traffic");
    for (int k = 0; k < 9; k++) begin
      case (k)
        0, 1: applyStimulus(1, 0, 14'h0081, 0, 0, 0, 0, 0);
        2, 3: begin applyStimulus(1, 0, 14'h0081, 0, 0, 0, 0, 0); reset = 1'b0; end
        4:    begin applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); reset = 1'b1; end
        6:    applyStimulus(1, 0, 14'h0082, 0, 0, 0, 0, 0);
        default: applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      @(negedge clk);
      if (k == 2) begin
        checkOutput("lit_rst_gnt", {31'd0, m0_gnt}, 32'd0);
        checkOutput("lit_rst_ram", {8'd0, res_rd, res_wr, res_addr, res_do}, 32'd0);
        checkOutput("lit_rst_rvalid", {31'd0, m0_rvalid}, 32'd0);
      end
      if (k == 4 || k == 5) checkOutput("lit_rst_norvalid", {31'd0, m0_rvalid}, 32'd0);
      if (k == 7) checkOutput("lit_rst_first_rd", {17'd0, res_rd, res_addr}, {17'd1, 14'h0082});
      if (k == 8) checkOutput("lit_rst_first_ret", {23'd0, m0_rvalid, m0_rdata}, 32'h104);
    end

    $display("[TB] contention with starvation guard");
    for (int k = 0; k < 18; k++) begin
      if (k < 17) applyStimulus(1, 0, 14'h0010, 0, 1, 0, 14'h0020, 0);
      else        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      if (k < 17) begin
        checkOutput("lit_cont_m1gnt", {31'd0, m1_gnt}, (k == 15) ? 32'd1 : 32'd0);
        checkOutput("lit_cont_m0gnt", {31'd0, m0_gnt}, (k == 15) ? 32'd0 : 32'd1);
      end
      if (k == 14) checkOutput("lit_cont_wait14", {24'd0, dut.wait_cnt}, 32'd14);
      if (k == 15) checkOutput("lit_cont_wait15", {24'd0, dut.wait_cnt}, 32'd15);
      if (k == 16) checkOutput("lit_cont_wait0", {24'd0, dut.wait_cnt}, 32'd0);
    end

    $display("[TB] host write then DT read of same address");
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: applyStimulus(0, 0, 0, 0, 1, 1, 14'h3F80, 8'h07);
        1: applyStimulus(1, 0, 14'h3F80, 8'hEE, 0, 0, 0, 0);
        default: applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      @(negedge clk);
      if (k == 1) checkOutput("lit_wr_strobe", {9'd0, res_rd, res_wr, res_addr, res_do},
                              {9'd0, 1'b0, 1'b1, 14'h3F80, 8'h07});
      if (k == 2) checkOutput("lit_rd_strobe", {9'd0, res_rd, res_wr, res_addr, res_do},
                              {9'd0, 1'b1, 1'b0, 14'h3F80, 8'hEE});
      if (k == 3) checkOutput("lit_wr_rd_data", {23'd0, m0_rvalid, m0_rdata}, 32'h107);
    end

    $display("[TB] RD_LAT=3 single host read");
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      d3_m1_req  = (k == 0);
      d3_m1_addr = 14'h1234;
      @(negedge clk);
      if (k == 0) checkOutput("lit_lat3_gnt", {31'd0, d3_m1_gnt}, 32'd1);
      checkOutput("lit_lat3_m1rvalid", {31'd0, d3_m1_rvalid}, (k == 4) ? 32'd1 : 32'd0);
      checkOutput("lit_lat3_m0rvalid", {31'd0, d3_m0_rvalid}, 32'd0);
      if (k == 4) checkOutput("lit_lat3_rdata", {24'd0, d3_m1_rdata}, 32'h91);
      if (d3_m1_rvalid) pulses++;
    end
    checkOutput("lit_lat3_pulses", pulses, 32'd1);

    $display("[TB] idle hold");
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("lit_idle_strobes", {30'd0, res_rd, res_wr}, 32'd0);
      checkOutput("lit_idle_hold", {10'd0, res_addr, res_do}, {10'd0, 14'h3F80, 8'hEE});
      checkOutput("lit_idle_wait", {24'd0, dut.wait_cnt}, 32'd0);
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
